// File: rtl/temp_conv_pkg.sv
// Shared constants and FSM state type for the temperature table writer.
package temp_conv_pkg;

    localparam int C_MAX    = 100;
    localparam int F_MAX    = 212;
    localparam int F_OFFSET = 32;

    localparam int C2F_MUL = 9;
    localparam int C2F_DIV = 5;
    localparam int F2C_MUL = 5;
    localparam int F2C_DIV = 9;

    // Half-divisor terms so the truncating divider rounds to nearest.
    localparam int C2F_RND = 2;
    localparam int F2C_RND = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/temp_table_writer_if.sv
// Boot-control handshake plus table RAM write port driven by the writer.
interface temp_table_writer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    modport master (
        input  start,
        output busy,
        output done,
        output we,
        output waddr,
        output wdata
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        input  we,
        input  waddr,
        input  wdata
    );
endinterface

// File: rtl/temp_div_serial.sv
// Serial restoring divider: one quotient bit per cycle, MSB first, DIV_W cycles.
module temp_div_serial #(
    parameter int DIV_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [DIV_W-1:0] num,
    input  logic [DIV_W-1:0] den,
    output logic [DIV_W-1:0] quotient,
    output logic             valid
);
    localparam int CNT_W = $clog2(DIV_W + 1);

    logic [DIV_W-1:0] r_rem;
    logic [DIV_W-1:0] r_quo;
    logic [DIV_W-1:0] r_den;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;

    logic [DIV_W-1:0] w_rem_src;
    logic [DIV_W-1:0] w_quo_src;
    logic [DIV_W-1:0] w_den_src;
    logic [DIV_W:0]   w_trial;
    logic             w_bit;
    logic [DIV_W-1:0] w_rem_next;

    // The go cycle already performs the first step directly on the new operands.
    always_comb begin
        w_rem_src  = go ? '0 : r_rem;
        w_quo_src  = go ? num : r_quo;
        w_den_src  = go ? den : r_den;
        w_trial    = {w_rem_src, w_quo_src[DIV_W-1]};
        w_bit      = (w_trial >= {1'b0, w_den_src});
        w_rem_next = w_bit ? DIV_W'(w_trial - {1'b0, w_den_src}) : w_trial[DIV_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_den   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (go) begin
                r_rem   <= w_rem_next;
                r_quo   <= {w_quo_src[DIV_W-2:0], w_bit};
                r_den   <= den;
                r_cnt   <= CNT_W'(DIV_W - 1);
                r_valid <= (DIV_W == 1);
            end else if (r_cnt != '0) begin
                r_rem   <= w_rem_next;
                r_quo   <= {w_quo_src[DIV_W-2:0], w_bit};
                r_cnt   <= r_cnt - CNT_W'(1);
                r_valid <= (r_cnt == CNT_W'(1));
            end
        end
    end

    assign quotient = r_quo;
    assign valid    = r_valid;

endmodule

// File: rtl/temp_table_writer.sv
// Fills the C->F and F->C conversion table, one computed entry every 12 cycles.
module temp_table_writer #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 10,
    parameter int C_MAX  = temp_conv_pkg::C_MAX,
    parameter int F_MAX  = temp_conv_pkg::F_MAX
) (
    input  logic               clk,
    input  logic               rst_n,
    temp_table_writer_if.master bus
);
    import temp_conv_pkg::*;

    localparam int IDX_W = ADDR_W - 1;
    localparam logic [IDX_W-1:0] C_LAST   = IDX_W'(C_MAX);
    localparam logic [IDX_W-1:0] F_LAST   = IDX_W'(F_MAX);
    localparam logic [IDX_W-1:0] F_ZERO_C = IDX_W'(F_OFFSET);

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_unit;
    logic [IDX_W-1:0]  r_idx;

    logic              w_go;
    logic              w_clamp;
    logic [DIV_W-1:0]  w_num;
    logic [DIV_W-1:0]  w_den;
    logic [DIV_W-1:0]  w_quo;
    logic              w_div_valid;
    logic [DATA_W-1:0] w_result;

    assign w_go    = (r_state == LOAD);
    // Fahrenheit below freezing would be negative Celsius; those entries read as 0.
    assign w_clamp = !r_unit && (r_idx < F_ZERO_C);

    always_comb begin
        w_num = '0;
        w_den = DIV_W'(F2C_DIV);
        if (r_unit) begin
            w_num = DIV_W'(C2F_MUL * int'(r_idx) + C2F_RND);
            w_den = DIV_W'(C2F_DIV);
        end else if (!w_clamp) begin
            w_num = DIV_W'(F2C_MUL * (int'(r_idx) - F_OFFSET) + F2C_RND);
        end
    end

    assign w_result = w_clamp ? '0
                    : (DATA_W'(w_quo) + (r_unit ? DATA_W'(F_OFFSET) : '0));

    temp_div_serial #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (w_go),
        .num      (w_num),
        .den      (w_den),
        .quotient (w_quo),
        .valid    (w_div_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_unit  <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                        r_unit  <= 1'b1;
                        r_idx   <= '0;
                    end
                end
                LOAD: r_state <= DIV;
                DIV: begin
                    if (w_div_valid) begin
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    r_we    <= 1'b1;
                    r_waddr <= {r_unit, r_idx};
                    r_wdata <= w_result;
                    if (r_unit) begin
                        r_state <= LOAD;
                        if (r_idx == C_LAST) begin
                            r_unit <= 1'b0;
                            r_idx  <= '0;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else if (r_idx == F_LAST) begin
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= LOAD;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.we    = r_we;
    assign bus.waddr = r_waddr;
    assign bus.wdata = r_wdata;

endmodule
